// File: rtl/alu_branch_unit.sv
// Execute-stage datapath: srcA select, 32-bit ALU with HI/LO multiply, and the
// conditional-branch next-PC resolver, each behind a level-enable/done handshake.
module alu_branch_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_en,
   input  logic [3:0]  alu_control,
   input  logic [31:0] read_data1,
   input  logic [4:0]  shamt,
   input  logic        select_shamt,
   input  logic [31:0] alu_srcB,
   output logic [31:0] alu_result,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        overflow,
   output logic        alu_zero,
   output logic        alu_done,
   input  logic        branch_en,
   input  logic        branch,
   input  logic [31:0] imm,
   input  logic [31:0] pc,
   output logic [31:0] pc_out,
   output logic        branch_done
);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_ADDU  = 4'd1;
   localparam logic [3:0] OP_SUB   = 4'd2;
   localparam logic [3:0] OP_SUBU  = 4'd3;
   localparam logic [3:0] OP_AND   = 4'd4;
   localparam logic [3:0] OP_OR    = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_NOR   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_SLL   = 4'd10;
   localparam logic [3:0] OP_SRL   = 4'd11;
   localparam logic [3:0] OP_SRA   = 4'd12;
   localparam logic [3:0] OP_MULT  = 4'd13;
   localparam logic [3:0] OP_MULTU = 4'd14;
   localparam logic [3:0] OP_LUI   = 4'd15;

   logic [31:0]        src_a;
   logic [31:0]        sum;
   logic [31:0]        diff;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        nxt_result;
   logic               nxt_ovf;
   logic               is_mult;
   logic               is_multu;

   assign src_a    = select_shamt ? {27'b0, shamt} : read_data1;
   assign sum      = src_a + alu_srcB;
   assign diff     = src_a - alu_srcB;
   assign prod_s   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{alu_srcB[31]}}, alu_srcB});
   assign prod_u   = {32'b0, src_a} * {32'b0, alu_srcB};
   assign is_mult  = (alu_control == OP_MULT);
   assign is_multu = (alu_control == OP_MULTU);

   always_comb begin
      nxt_result = '0;
      nxt_ovf    = 1'b0;
      case (alu_control)
         OP_ADD: begin
            nxt_result = sum;
            nxt_ovf    = (src_a[31] == alu_srcB[31]) && (sum[31] != src_a[31]);
         end
         OP_ADDU:  nxt_result = sum;
         OP_SUB: begin
            nxt_result = diff;
            nxt_ovf    = (src_a[31] != alu_srcB[31]) && (diff[31] != src_a[31]);
         end
         OP_SUBU:  nxt_result = diff;
         OP_AND:   nxt_result = src_a & alu_srcB;
         OP_OR:    nxt_result = src_a | alu_srcB;
         OP_XOR:   nxt_result = src_a ^ alu_srcB;
         OP_NOR:   nxt_result = ~(src_a | alu_srcB);
         OP_SLT:   nxt_result = {31'b0, $signed(src_a) < $signed(alu_srcB)};
         OP_SLTU:  nxt_result = {31'b0, src_a < alu_srcB};
         OP_SLL:   nxt_result = alu_srcB << src_a[4:0];
         OP_SRL:   nxt_result = alu_srcB >> src_a[4:0];
         OP_SRA:   nxt_result = $signed(alu_srcB) >>> src_a[4:0];
         OP_MULT:  nxt_result = prod_s[31:0];
         OP_MULTU: nxt_result = prod_u[31:0];
         OP_LUI:   nxt_result = alu_srcB << 16;
         default:  nxt_result = '0;
      endcase
   end

   // Handshake: a request (en) is a level held until done. Capture happens on the
   // first edge with en=1 and done=0; done then stays high while en is held and
   // clears on the first edge with en=0. Outputs hold between captures.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result <= '0;
         hi         <= '0;
         lo         <= '0;
         overflow   <= 1'b0;
         alu_zero   <= 1'b0;
         alu_done   <= 1'b0;
      end else if (alu_en && !alu_done) begin
         alu_result <= nxt_result;
         overflow   <= nxt_ovf;
         alu_zero   <= (nxt_result == 32'd0);
         alu_done   <= 1'b1;
         if (is_mult) begin
            hi <= prod_s[63:32];
            lo <= prod_s[31:0];
         end else if (is_multu) begin
            hi <= prod_u[63:32];
            lo <= prod_u[31:0];
         end
      end else if (!alu_en) begin
         alu_done <= 1'b0;
      end
   end

   // Uses the registered alu_zero, so a same-edge ALU capture is not yet visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_out      <= '0;
         branch_done <= 1'b0;
      end else if (branch_en && !branch_done) begin
         pc_out      <= (branch && alu_zero) ? (pc + imm) : pc;
         branch_done <= 1'b1;
      end else if (!branch_en) begin
         branch_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed self-checking bench for alu_branch_unit: reset, ALU ops, flags,
// HI/LO behaviour, branch resolution and reset during a handshake.
module tb_alu_branch_unit;

   logic        clk;
   logic        rst_n;
   logic        alu_en;
   logic [3:0]  alu_control;
   logic [31:0] read_data1;
   logic [4:0]  shamt;
   logic        select_shamt;
   logic [31:0] alu_srcB;
   logic [31:0] alu_result;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        overflow;
   logic        alu_zero;
   logic        alu_done;
   logic        branch_en;
   logic        branch;
   logic [31:0] imm;
   logic [31:0] pc;
   logic [31:0] pc_out;
   logic        branch_done;

   int n_checks = 0;
   int n_fail   = 0;

   alu_branch_unit dut (
      .clk(clk), .rst_n(rst_n), .alu_en(alu_en), .alu_control(alu_control),
      .read_data1(read_data1), .shamt(shamt), .select_shamt(select_shamt),
      .alu_srcB(alu_srcB), .alu_result(alu_result), .hi(hi), .lo(lo),
      .overflow(overflow), .alu_zero(alu_zero), .alu_done(alu_done),
      .branch_en(branch_en), .branch(branch), .imm(imm), .pc(pc),
      .pc_out(pc_out), .branch_done(branch_done)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: called just after an edge, return 1 time unit after the capture edge.
   task automatic start_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic sel, input logic [4:0] sh);
      alu_control  = op;
      read_data1   = a;
      alu_srcB     = b;
      select_shamt = sel;
      shamt        = sh;
      alu_en       = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic stop_alu();
      alu_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic start_branch(input logic br, input logic [31:0] p, input logic [31:0] off);
      branch    = br;
      pc        = p;
      imm       = off;
      branch_en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic stop_branch();
      branch_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      n_checks++; if ({alu_result, hi, lo, pc_out} !== 128'd0) begin n_fail++; $display("FAIL reset_words: got %h %h %h %h expected all 0", alu_result, hi, lo, pc_out); end
      n_checks++; if ({overflow, alu_zero, alu_done, branch_done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {overflow, alu_zero, alu_done, branch_done}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      // Leave non-zero state behind, then assert reset mid-cycle.
      start_alu(4'd13, 32'd7, 32'd9, 1'b0, 5'd0);
      start_branch(1'b0, 32'd33, 32'd0);
      alu_en = 1'b0; branch_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({alu_result, hi, lo, pc_out} !== 128'd0) begin n_fail++; $display("FAIL async_reset_words: got %h %h %h %h expected all 0", alu_result, hi, lo, pc_out); end
      n_checks++; if ({alu_done, branch_done} !== 2'b00) begin n_fail++; $display("FAIL async_reset_done: got %b expected 00", {alu_done, branch_done}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_handshake();
      start_alu(4'd0, 32'd5, 32'd7, 1'b0, 5'd0);
      n_checks++; if (alu_done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b expected 1", alu_done); end
      n_checks++; if (alu_result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h expected %h", alu_result, 32'd12); end
      // Changed operands while held must not be recomputed.
      read_data1 = 32'd100;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; if (alu_done !== 1'b1 || alu_result !== 32'd12) begin n_fail++; $display("FAIL hold_%0d: got done=%b result=%h expected done=1 result=0000000c", i, alu_done, alu_result); end
      end
      stop_alu();
      n_checks++; if (alu_done !== 1'b0 || alu_result !== 32'd12) begin n_fail++; $display("FAIL add_release: got done=%b result=%h expected done=0 result=0000000c", alu_done, alu_result); end
   endtask

   task automatic test_overflow_compare();
      start_alu(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 5'd0);
      n_checks++; if (alu_result !== 32'h8000_0000 || overflow !== 1'b1 || alu_zero !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %h ovf=%b z=%b expected 80000000 ovf=1 z=0", alu_result, overflow, alu_zero); end
      stop_alu();
      start_alu(4'd2, 32'd5, 32'd5, 1'b0, 5'd0);
      n_checks++; if (alu_result !== 32'd0 || overflow !== 1'b0 || alu_zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %h ovf=%b z=%b expected 00000000 ovf=0 z=1", alu_result, overflow, alu_zero); end
      stop_alu();
      start_alu(4'd2, 32'h8000_0000, 32'd1, 1'b0, 5'd0);
      n_checks++; if (alu_result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin n_fail++; $display("FAIL sub_ovf: got %h ovf=%b expected 7fffffff ovf=1", alu_result, overflow); end
      stop_alu();
      start_alu(4'd1, 32'h7FFF_FFFF, 32'd1, 1'b0, 5'd0);
      n_checks++; if (alu_result !== 32'h8000_0000 || overflow !== 1'b0) begin n_fail++; $display("FAIL addu_no_ovf: got %h ovf=%b expected 80000000 ovf=0", alu_result, overflow); end
      stop_alu();
      start_alu(4'd3, 32'd2, 32'd3, 1'b0, 5'd0);
      n_checks++; if (alu_result !== 32'hFFFF_FFFF || overflow !== 1'b0) begin n_fail++; $display("FAIL subu: got %h ovf=%b expected ffffffff ovf=0", alu_result, overflow); end
      stop_alu();
      start_alu(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0);
      n_checks++; if (alu_result !== 32'd1) begin n_fail++; $display("FAIL slt: got %h expected 00000001", alu_result); end
      stop_alu();
      start_alu(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0);
      n_checks++; if (alu_result !== 32'd0 || alu_zero !== 1'b1) begin n_fail++; $display("FAIL sltu: got %h z=%b expected 00000000 z=1", alu_result, alu_zero); end
      stop_alu();
   endtask

   task automatic test_logic();
      logic [3:0]  ops [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd15};
      logic [31:0] exps[5] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F, 32'hFF00_0000};
      for (int i = 0; i < 5; i++) begin
         start_alu(ops[i], 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 5'd0);
         n_checks++; if (alu_result !== exps[i]) begin n_fail++; $display("FAIL logic_op%0d: got %h expected %h", ops[i], alu_result, exps[i]); end
         stop_alu();
      end
   endtask

   task automatic test_shifts();
      logic [3:0]  ops [3] = '{4'd10, 4'd11, 4'd12};
      logic [31:0] exps[3] = '{32'h0000_0000, 32'h0F00_0000, 32'hFF00_0000};
      for (int i = 0; i < 3; i++) begin
         start_alu(ops[i], 32'hFFFF_FFFF, 32'hF000_0000, 1'b1, 5'd4);
         n_checks++; if (alu_result !== exps[i]) begin n_fail++; $display("FAIL shift_op%0d: got %h expected %h", ops[i], alu_result, exps[i]); end
         stop_alu();
      end
      // Register operand path: SRL by read_data1 = 8
      start_alu(4'd11, 32'd8, 32'hF000_0000, 1'b0, 5'd4);
      n_checks++; if (alu_result !== 32'h00F0_0000) begin n_fail++; $display("FAIL srl_reg: got %h expected 00f00000", alu_result); end
      stop_alu();
   endtask

   task automatic test_multiply();
      start_alu(4'd13, 32'hFFFF_FFFE, 32'd3, 1'b0, 5'd0);
      n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA || alu_result !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult: got hi=%h lo=%h res=%h expected ffffffff fffffffa fffffffa", hi, lo, alu_result); end
      stop_alu();
      start_alu(4'd0, 32'd1, 32'd1, 1'b0, 5'd0);
      n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA || alu_result !== 32'd2) begin n_fail++; $display("FAIL mult_hold: got hi=%h lo=%h res=%h expected ffffffff fffffffa 00000002", hi, lo, alu_result); end
      stop_alu();
      start_alu(4'd14, 32'hFFFF_FFFF, 32'd2, 1'b0, 5'd0);
      n_checks++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu: got hi=%h lo=%h expected 00000001 fffffffe", hi, lo); end
      stop_alu();
   endtask

   task automatic test_branch();
      start_alu(4'd2, 32'd3, 32'd3, 1'b0, 5'd0);
      stop_alu();
      start_branch(1'b1, 32'd10, 32'hFFFF_FFFC);
      n_checks++; if (branch_done !== 1'b1 || pc_out !== 32'd6) begin n_fail++; $display("FAIL br_taken: got done=%b pc=%0d expected done=1 pc=6", branch_done, pc_out); end
      stop_branch();
      n_checks++; if (branch_done !== 1'b0 || pc_out !== 32'd6) begin n_fail++; $display("FAIL br_release: got done=%b pc=%0d expected done=0 pc=6", branch_done, pc_out); end
      start_branch(1'b0, 32'd10, 32'hFFFF_FFFC);
      n_checks++; if (pc_out !== 32'd10) begin n_fail++; $display("FAIL br_nonbranch: got %0d expected 10", pc_out); end
      stop_branch();
      start_branch(1'b1, 32'd10, 32'hFFFF_FFFC);
      stop_branch();
      start_alu(4'd2, 32'd3, 32'd2, 1'b0, 5'd0);
      stop_alu();
      start_branch(1'b1, 32'd10, 32'hFFFF_FFFC);
      n_checks++; if (pc_out !== 32'd10) begin n_fail++; $display("FAIL br_not_taken: got %0d expected 10", pc_out); end
      stop_branch();
      // Same-edge capture: alu_zero is still 0 from SUB 3-2 when the branch resolves.
      pc = 32'd20;
      branch = 1'b1;
      imm = 32'd5;
      branch_en = 1'b1;
      start_alu(4'd2, 32'd3, 32'd3, 1'b0, 5'd0);
      n_checks++; if (pc_out !== 32'd20 || alu_zero !== 1'b1) begin n_fail++; $display("FAIL br_same_edge: got pc=%0d z=%b expected pc=20 z=1", pc_out, alu_zero); end
      alu_en = 1'b0;
      stop_branch();
      start_branch(1'b1, 32'd20, 32'd5);
      n_checks++; if (pc_out !== 32'd25) begin n_fail++; $display("FAIL br_after_same_edge: got %0d expected 25", pc_out); end
      stop_branch();
   endtask

   task automatic test_reset_mid_handshake();
      start_alu(4'd0, 32'd5, 32'd7, 1'b0, 5'd0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (alu_done !== 1'b0 || alu_result !== 32'd0) begin n_fail++; $display("FAIL rst_mid: got done=%b res=%h expected done=0 res=00000000", alu_done, alu_result); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (alu_done !== 1'b1 || alu_result !== 32'd12) begin n_fail++; $display("FAIL rst_recompute: got done=%b res=%h expected done=1 res=0000000c", alu_done, alu_result); end
      stop_alu();
   endtask

   initial begin
      rst_n = 1'b0; alu_en = 1'b0; alu_control = '0; read_data1 = '0; shamt = '0;
      select_shamt = 1'b0; alu_srcB = '0; branch_en = 1'b0; branch = 1'b0; imm = '0; pc = '0;
      #12;
      test_reset();
      test_handshake();
      test_overflow_compare();
      test_logic();
      test_shifts();
      test_multiply();
      test_branch();
      test_reset_mid_handshake();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_branch_unit.md
# alu_branch_unit

Execute-stage datapath block for the multi-cycle MIPS core. It contains the ALU operand-A select (register or shift amount), a 32-bit ALU with HI/LO multiply results, and the conditional-branch PC resolver. The control unit drives it with level-enable/done handshakes in its EXECUTE and BRANCH states. The block sits between the register file/immediate mux and the memory, writeback and PC-update logic.

## Interface
- Parameters: none. Data width is fixed at 32 bits. PC is a word index.
- Clocking/reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_en  in  1  ALU request; level, held by controller until alu_done
- alu_control  in  4  operation code (see Operation)
- read_data1  in  32  rs value
- shamt  in  5  instruction shift amount
- select_shamt  in  1  1: srcA = {27'b0, shamt}; 0: srcA = read_data1
- alu_srcB  in  32  rt value or extended immediate (muxed upstream)
- alu_result  out  32  registered result
- hi, lo  out  32 each  registered multiply high/low words
- overflow  out  1  signed overflow of ADD/SUB
- alu_zero  out  1  1 when alu_result == 0
- alu_done  out  1  ALU completion flag
- branch_en  in  1  branch request; level, held until branch_done
- branch  in  1  instruction is a branch (from decoder)
- imm  in  32  sign-extended word offset
- pc  in  32  already-incremented PC (pc+1)
- pc_out  out  32  next PC
- branch_done  out  1  branch completion flag

## Operation
- srcA mux is combinational: srcA = select_shamt ? {27'b0, shamt} : read_data1.
- alu_control codes (A = srcA, B = alu_srcB):
  - 0 ADD (signed, sets overflow)
  - 1 ADDU
  - 2 SUB A-B (signed, sets overflow)
  - 3 SUBU
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOR
  - 8 SLT (signed, result 0/1)
  - 9 SLTU
  - 10 SLL B<<A[4:0]
  - 11 SRL
  - 12 SRA (arithmetic)
  - 13 MULT signed {hi,lo}=A*B
  - 14 MULTU
  - 15 LUI B<<16
- Overflow definition: set when operand signs match and the result sign differs (ADD), or operand signs differ and the result sign differs from A (SUB). For all other codes, overflow = 0.
- MULT/MULTU: alu_result = low 32 bits of the product. hi/lo change only on codes 13 and 14 and hold for every other operation.
- alu_zero is computed from the new alu_result and registered with it.
- Branch: if branch && alu_zero, pc_out = pc + imm (32-bit wrap, no trap). Otherwise pc_out = pc.

## Timing
- Reset: alu_result, hi, lo, pc_out = 0; overflow, alu_zero, alu_done, branch_done = 0. Reset applies immediately regardless of clk. If reset asserts mid-operation, the request is abandoned; the controller must re-request after reset releases.
- ALU handshake:
  - On a rising edge with alu_en=1 and alu_done=0, the block registers alu_result, overflow, alu_zero and (if multiply) hi/lo, and sets alu_done=1. Latency is 1 cycle.
  - While alu_en stays 1, alu_done stays 1 and outputs hold, with no recompute.
  - On an edge with alu_en=0, alu_done clears. Result outputs keep their values until the next operation, so the MEMORY and REGWRITE states can consume them.
  - A new operation requires alu_en to be low for at least one edge.
- Branch handshake: identical to the ALU handshake, using branch_en, branch_done and pc_out.
  - pc_out is computed from the alu_zero, branch, imm and pc values present at the capture edge.
  - pc_out holds until the next branch capture.
- ALU and branch requests are independent. If both capture on the same edge, the branch uses the pre-edge alu_zero.
- No combinational path exists from any input to any output except inside the srcA mux, which is internal.

## Test plan
- Reset: drive rst_n=0 mid-cycle -> all outputs 0 immediately. Release, then ADD 5+7 -> alu_result=12, alu_done=1 one edge after alu_en; hold alu_en 3 cycles -> alu_done stays 1, result stable; drop alu_en -> alu_done=0 next edge, result still 12.
- Overflow/compare:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - SUB 5-5 -> 0, alu_zero=1, overflow=0.
  - SLT -1,1 -> 1.
  - SLTU -1,1 -> 0.
- Shifts with select_shamt=1, shamt=4, B=0xF0000000, read_data1=0xFFFFFFFF (must be ignored):
  - SLL -> 0x00000000
  - SRL -> 0x0F000000
  - SRA -> 0xFF000000
- MULT -2*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; following ADD leaves hi/lo unchanged. MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- Branch cases, with pc=10:
  - Taken: branch=1, SUB 3-3 (zero), imm=-4 -> pc_out=6, branch_done one edge after branch_en.
  - Not taken: SUB 3-2 -> pc_out=10.
  - Non-branch: branch=0 with zero result -> pc_out=10.
- Reset mid-handshake: assert rst_n=0 while alu_en=1 and alu_done=1 -> alu_done=0. Release with alu_en still 1 -> recompute, alu_done=1 after one edge.
